cpc_ram_bank_ctrl: RTL and testbench

- Banking controller on a RAM-expansion card that plugs into any backplane socket.
- Snoops Z80 I/O writes to the gate-array RAM configuration port (A15=0, D7:6=11) and holds the current bank/mode.
- Decodes each memory cycle: when an expansion block is mapped, drives RAMDIS to the backplane and chip-select, output-enable and high address lines to the card's SRAM.
- Consumes the backplane bus signals unbuffered. It is the direct downstream consumer of the backplane.

---
 rtl/cpc_ram_bank_ctrl.sv | 123 ++++++++++++
 tb/tb_cpc_ram_bank_ctrl.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/cpc_ram_bank_ctrl.sv
// CPC RAM-expansion banking controller: snoops gate-array RAM config writes and
// decodes each memory cycle onto the card SRAM (RAMDIS, CE/OE/WE, high address).
module cpc_ram_bank_ctrl #(
  parameter int unsigned NBANK_BITS = 3
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic                  A15,
  input  logic                  A14,
  input  logic [7:0]            D,
  input  logic                  IOREQ_B,
  input  logic                  MREQ_B,
  input  logic                  M1_B,
  input  logic                  RFSH_B,
  input  logic                  RD_B,
  input  logic                  WR_B,
  input  logic                  ROMEN_B,
  output logic                  RAMDIS,
  output logic                  RAM_CE_B,
  output logic                  RAM_OE_B,
  output logic                  RAM_WE_B,
  output logic [NBANK_BITS+1:0] RA,
  output logic [2:0]            CFG_MODE,
  output logic [NBANK_BITS-1:0] CFG_BANK
);

  localparam int unsigned RaW = NBANK_BITS + 2;

  localparam logic [2:0] ModeInt    = 3'd0;
  localparam logic [2:0] ModeTop    = 3'd1;
  localparam logic [2:0] ModeAll    = 3'd2;
  localparam logic [2:0] ModeTopAlt = 3'd3;

  logic                  iowr_d, iowr_q;
  logic [2:0]            mode_d, mode_q;
  logic [NBANK_BITS-1:0] bank_d, bank_q;
  logic [RaW-1:0]        ra_d, ra_q;

  logic                  iowr;
  logic                  load;
  logic [1:0]            blk;
  logic                  mem;
  logic                  mapped;
  logic [1:0]            exp_idx;
  logic                  sel;
  logic [RaW-1:0]        ra_new;

  // Interrupt acknowledge (M1 low with IOREQ) must never look like an OUT.
  assign iowr = !IOREQ_B && !WR_B && M1_B && !A15 && D[7] && D[6];
  assign load = iowr && !iowr_q;

  always_comb begin
    iowr_d = iowr;
    mode_d = mode_q;
    bank_d = bank_q;
    if (load) begin
      mode_d = D[2:0];
      bank_d = D[3 +: NBANK_BITS];
    end
  end

  assign blk = {A15, A14};
  assign mem = !MREQ_B && RFSH_B;

  always_comb begin
    mapped  = 1'b0;
    exp_idx = 2'd0;
    case (mode_q)
      ModeInt: begin
        mapped  = 1'b0;
        exp_idx = 2'd0;
      end
      // The 4000 remap in mode 3 is handled by the host, so both only take C000.
      ModeTop, ModeTopAlt: begin
        mapped  = (blk == 2'd3);
        exp_idx = 2'd3;
      end
      ModeAll: begin
        mapped  = 1'b1;
        exp_idx = blk;
      end
      default: begin
        mapped  = (blk == 2'd1);
        exp_idx = mode_q[1:0];
      end
    endcase
  end

  assign sel    = mem && mapped && !RESET;
  assign ra_new = {bank_q, exp_idx};

  // Address lines hold their last driven value while idle to avoid SRAM glitches.
  always_comb begin
    ra_d = ra_q;
    if (sel) begin
      ra_d = ra_new;
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      iowr_q <= 1'b0;
      mode_q <= 3'd0;
      bank_q <= '0;
      ra_q   <= '0;
    end else begin
      iowr_q <= iowr_d;
      mode_q <= mode_d;
      bank_q <= bank_d;
      ra_q   <= ra_d;
    end
  end

  assign RAMDIS   = sel;
  assign RAM_CE_B = !sel;
  assign RAM_WE_B = !(sel && !WR_B);
  // Enabled ROM wins reads; the SRAM stays off the bus but still accepts writes.
  assign RAM_OE_B = !(sel && !RD_B && ROMEN_B);
  assign RA       = sel ? ra_new : ra_q;
  assign CFG_MODE = mode_q;
  assign CFG_BANK = bank_q;

endmodule

// File: tb/tb_cpc_ram_bank_ctrl.sv
// Self-checking bench for cpc_ram_bank_ctrl: directed scenarios followed by
// random bus traffic, all compared against a behavioural banking model.
module tb_cpc_ram_bank_ctrl;

  localparam int unsigned NB = 3;

  logic          CLK = 1'b0;
  logic          RESET;
  logic [15:0]   addr;
  logic          A15, A14;
  logic [7:0]    D;
  logic          IOREQ_B, MREQ_B, M1_B, RFSH_B, RD_B, WR_B, ROMEN_B;
  logic          RAMDIS, RAM_CE_B, RAM_OE_B, RAM_WE_B;
  logic [NB+1:0] RA;
  logic [2:0]    CFG_MODE;
  logic [NB-1:0] CFG_BANK;

  assign A15 = addr[15];
  assign A14 = addr[14];

  cpc_ram_bank_ctrl #(.NBANK_BITS(NB)) dut (
    .CLK      (CLK),
    .RESET    (RESET),
    .A15      (A15),
    .A14      (A14),
    .D        (D),
    .IOREQ_B  (IOREQ_B),
    .MREQ_B   (MREQ_B),
    .M1_B     (M1_B),
    .RFSH_B   (RFSH_B),
    .RD_B     (RD_B),
    .WR_B     (WR_B),
    .ROMEN_B  (ROMEN_B),
    .RAMDIS   (RAMDIS),
    .RAM_CE_B (RAM_CE_B),
    .RAM_OE_B (RAM_OE_B),
    .RAM_WE_B (RAM_WE_B),
    .RA       (RA),
    .CFG_MODE (CFG_MODE),
    .CFG_BANK (CFG_BANK)
  );

  always #5 CLK = ~CLK;

  int errors = 0;
  int checks = 0;

  // Reference model state
  int m_mode, m_bank, m_ra;
  bit m_prev_strobe;

  // Expansion block for a (mode, 16K block) pair, or -1 for internal RAM.
  function automatic int exp_block(input int mode, input int b);
    if (mode == 2) return b;
    if ((mode == 1 || mode == 3) && b == 3) return 3;
    if (mode >= 4 && b == 1) return mode - 4;
    return -1;
  endfunction

  function automatic bit model_sel();
    return !RESET && !MREQ_B && RFSH_B && exp_block(m_mode, int'(addr[15:14])) >= 0;
  endfunction

  function automatic int model_ra_live();
    return m_bank * 4 + exp_block(m_mode, int'(addr[15:14]));
  endfunction

  task automatic model_reset();
    m_mode = 0; m_bank = 0; m_ra = 0; m_prev_strobe = 0;
  endtask

  task automatic model_edge();
    bit strobe;
    if (RESET) begin
      model_reset();
    end else begin
      if (model_sel()) m_ra = model_ra_live();
      strobe = !IOREQ_B && !WR_B && M1_B && !addr[15] && (D[7:6] == 2'b11);
      if (strobe && !m_prev_strobe) begin
        m_mode = D & 7;
        m_bank = (D >> 3) & ((1 << NB) - 1);
      end
      m_prev_strobe = strobe;
    end
  endtask

  task automatic cmp(input string tag, input string name, input logic [7:0] got,
                     input logic [7:0] exp);
    checks++;
    assert (got === exp)
    else begin
      errors++;
      $error("FAIL %s %s got=%0h expected=%0h", tag, name, got, exp);
    end
  endtask

  task automatic check(input string tag);
    bit sel;
    int ra_e;
    sel  = model_sel();
    ra_e = sel ? model_ra_live() : m_ra;
    cmp(tag, "RAMDIS",   8'(RAMDIS),   8'(sel));
    cmp(tag, "RAM_CE_B", 8'(RAM_CE_B), 8'(!sel));
    cmp(tag, "RAM_WE_B", 8'(RAM_WE_B), 8'(!(sel && !WR_B)));
    cmp(tag, "RAM_OE_B", 8'(RAM_OE_B), 8'(!(sel && !RD_B && ROMEN_B)));
    cmp(tag, "RA",       8'(RA),       8'(ra_e));
    cmp(tag, "CFG_MODE", 8'(CFG_MODE), 8'(m_mode));
    cmp(tag, "CFG_BANK", 8'(CFG_BANK), 8'(m_bank));
  endtask

  task automatic tick(input string tag);
    @(posedge CLK);
    model_edge();
    #1;
    check(tag);
  endtask

  task automatic bus_idle();
    IOREQ_B = 1; MREQ_B = 1; M1_B = 1; RFSH_B = 1; RD_B = 1; WR_B = 1; ROMEN_B = 1;
    addr = 16'h0000; D = 8'h00;
  endtask

  task automatic io_out(input logic [15:0] a, input logic [7:0] d, input logic m1);
    bus_idle();
    addr = a; D = d; IOREQ_B = 0; WR_B = 0; M1_B = m1;
  endtask

  task automatic mem_rd(input logic [15:0] a, input logic romen);
    bus_idle();
    addr = a; MREQ_B = 0; RD_B = 0; ROMEN_B = romen;
  endtask

  task automatic mem_wr(input logic [15:0] a);
    bus_idle();
    addr = a; MREQ_B = 0; WR_B = 0; D = 8'($urandom);
  endtask

  task automatic do_out(input string tag, input logic [7:0] d);
    io_out(16'h7F00, d, 1'b1); tick(tag);
    bus_idle();                tick(tag);
  endtask

  initial begin
    bus_idle();
    model_reset();
    RESET = 1;
    #12;
    check("reset");
    @(negedge CLK);
    RESET = 0;
    tick("reset_rel");

    mem_rd(16'hC000, 1); tick("m0_rd_c000");
    cmp("m0_rd_c000", "RAMDIS_lit", 8'(RAMDIS), 8'h00);

    do_out("out_c1", 8'hC1);
    mem_rd(16'hC123, 1); tick("m1_rd_c123");
    cmp("m1_rd_c123", "RA_lit", 8'(RA), 8'h03);
    mem_rd(16'h4000, 1); tick("m1_rd_4000");

    do_out("out_fe", 8'hFE);
    mem_wr(16'h4010);    tick("m6_wr_4010");
    cmp("m6_wr_4010", "RA_lit", 8'(RA), 8'h1E);
    mem_rd(16'hC000, 0); tick("m6_rom_c000");

    do_out("out_d2", 8'hD2);
    mem_rd(16'h8000, 1); RFSH_B = 0; tick("m2_rfsh");
    cmp("m2_rfsh", "RAM_CE_B_lit", 8'(RAM_CE_B), 8'h01);
    mem_rd(16'h8000, 1); tick("m2_rd_8000");
    cmp("m2_rd_8000", "RA_lit", 8'(RA), 8'h0A);

    bus_idle(); tick("idle");
    io_out(16'h7F00, 8'hC4, 1); tick("hold1");
    D = 8'hC5;                  tick("hold2");
    D = 8'hC7;                  tick("hold3");
    cmp("hold3", "CFG_MODE_lit", 8'(CFG_MODE), 8'h04);
    bus_idle(); tick("idle");
    do_out("out_8f", 8'h8F);
    io_out(16'h7F00, 8'hC7, 0); tick("inta");
    bus_idle(); tick("idle");
    cmp("ignored", "CFG_MODE_lit", 8'(CFG_MODE), 8'h04);

    do_out("out_d2b", 8'hD2);
    mem_rd(16'h0000, 1); tick("m2_rd_0000");
    #2;
    RESET = 1;
    #1;
    model_reset();
    check("async_reset");
    cmp("async_reset", "RAMDIS_lit", 8'(RAMDIS), 8'h00);
    tick("in_reset");
    @(negedge CLK);
    RESET = 0;
    tick("post_reset");

    for (int i = 0; i < 400; i++) begin
      int op;
      op = $urandom_range(0, 9);
      if (op <= 2) begin
        io_out(16'($urandom), 8'($urandom), 1'($urandom_range(0, 7) != 0));
        addr[15] = ($urandom_range(0, 7) == 0);
        if ($urandom_range(0, 3) != 0) D[7:6] = 2'b11;
      end else if (op <= 7) begin
        if ($urandom_range(0, 1) == 0) mem_rd(16'($urandom), 1'($urandom));
        else mem_wr(16'($urandom));
        RFSH_B  = ($urandom_range(0, 4) != 0);
        M1_B    = 1'($urandom);
        ROMEN_B = 1'($urandom);
      end else begin
        bus_idle();
      end
      tick("random");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
